// File: rtl/tetris_move_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_move_ctrl
//
// Purpose:
//   Runs every move of the active piece through the field collision checker.
//   A player command is latched in IDLE, a candidate position/rotation is
//   computed (PRECHK), driven to the block expander and field checker for
//   CHK_LAT cycles (PROBE), and the sampled checker error decides whether
//   the candidate is committed, rejected, or the piece is locked (RESOLVE /
//   LOCK). This block owns the committed piece position.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid, cmd[2:0]   command request (0 left, 1 right, 2 down, 3 rotate,
//                         4 spawn, 5 hard drop when enabled, else illegal)
//   cmd_ready             high only in IDLE
//   cand_x/y/rot          candidate position to expander / checker
//   chk_err               checker error (collision or bit loss)
//   pos_x/y/rot           committed position
//   done, accepted        completion pulse and its result
//   lock_pulse            merge piece into background
//   game_over             sticky until reset
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_valid while busy is ignored, never queued.
//
// Optional feature: define TETRIS_HARD_DROP_EN to enable cmd=5 (hard drop).
//
// Result pulses (done, accepted, lock_pulse) are registered: they are set on
// the edge that leaves RESOLVE/LOCK, so they are visible in the following
// cycle, together with the updated pos_* and cmd_ready=1.
// -----------------------------------------------------------------------------
module tetris_move_ctrl #(
    parameter int COLS    = 20,
    parameter int ROWS    = 20,
    parameter int CHK_LAT = 1,
    parameter int SPAWN_X = 8,
    parameter int SPAWN_Y = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    output logic [4:0] cand_x,
    output logic [4:0] cand_y,
    output logic [1:0] cand_rot,
    input  logic       chk_err,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic [1:0] pos_rot,
    output logic       done,
    output logic       accepted,
    output logic       lock_pulse,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRECHK  = 3'd1,
        S_PROBE   = 3'd2,
        S_RESOLVE = 3'd3,
        S_LOCK    = 3'd4
    } state_t;

    localparam logic [2:0] CMD_LEFT  = 3'd0;
    localparam logic [2:0] CMD_RIGHT = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_ROT   = 3'd3;
    localparam logic [2:0] CMD_SPAWN = 3'd4;
`ifdef TETRIS_HARD_DROP_EN
    localparam logic [2:0] CMD_HARD  = 3'd5;
`endif

    localparam logic [4:0] X_MAX    = 5'(COLS - 1);
    localparam logic [4:0] Y_MAX    = 5'(ROWS - 1);
    localparam logic [4:0] SX       = 5'(SPAWN_X);
    localparam logic [4:0] SY       = 5'(SPAWN_Y);
    localparam logic [2:0] LAT_LAST = 3'(CHK_LAT - 1);

    state_t     state_q;
    logic [2:0] cmd_q;
    logic [2:0] cnt_q;
    logic       err_q;
    logic       rej_q;
    logic [4:0] pos_x_q, pos_y_q, cand_x_q, cand_y_q;
    logic [1:0] pos_rot_q, cand_rot_q;
    logic       done_q, accepted_q, lock_q, game_over_q;

    // Candidate for the latched command, plus the two short-cut decisions
    // that skip the probe entirely.
    logic [4:0] cand_x_d, cand_y_d;
    logic [1:0] cand_rot_d;
    logic       pre_rej_d, pre_lock_d;

    always_comb begin
        cand_x_d   = pos_x_q;
        cand_y_d   = pos_y_q;
        cand_rot_d = pos_rot_q;
        pre_rej_d  = 1'b0;
        pre_lock_d = 1'b0;
        case (cmd_q)
            CMD_LEFT:  if (pos_x_q == 5'd0)  pre_rej_d  = 1'b1; else cand_x_d = pos_x_q - 5'd1;
            CMD_RIGHT: if (pos_x_q == X_MAX) pre_rej_d  = 1'b1; else cand_x_d = pos_x_q + 5'd1;
            CMD_DOWN:  if (pos_y_q == Y_MAX) pre_lock_d = 1'b1; else cand_y_d = pos_y_q + 5'd1;
            CMD_ROT:   cand_rot_d = pos_rot_q + 2'd1;
            CMD_SPAWN: begin
                cand_x_d   = SX;
                cand_y_d   = SY;
                cand_rot_d = 2'd0;
            end
`ifdef TETRIS_HARD_DROP_EN
            CMD_HARD:  if (pos_y_q == Y_MAX) pre_lock_d = 1'b1; else cand_y_d = pos_y_q + 5'd1;
`endif
            default:   pre_rej_d = 1'b1;
        endcase
        // A finished game rejects everything, spawn included.
        if (game_over_q) begin
            pre_rej_d  = 1'b1;
            pre_lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 3'd0;
            cnt_q       <= 3'd0;
            err_q       <= 1'b0;
            rej_q       <= 1'b0;
            pos_x_q     <= SX;
            pos_y_q     <= SY;
            pos_rot_q   <= 2'd0;
            cand_x_q    <= SX;
            cand_y_q    <= SY;
            cand_rot_q  <= 2'd0;
            done_q      <= 1'b0;
            accepted_q  <= 1'b0;
            lock_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            accepted_q <= 1'b0;
            lock_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q   <= cmd;
                        state_q <= S_PRECHK;
                    end
                end
                S_PRECHK: begin
                    cnt_q <= 3'd0;
                    rej_q <= pre_rej_d;
                    if (pre_rej_d) begin
                        state_q <= S_RESOLVE;      // cand_* stay equal to pos_*
                    end else if (pre_lock_d) begin
                        state_q <= S_LOCK;
                    end else begin
                        cand_x_q   <= cand_x_d;
                        cand_y_q   <= cand_y_d;
                        cand_rot_q <= cand_rot_d;
                        state_q    <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (cnt_q == LAT_LAST) begin
`ifdef TETRIS_HARD_DROP_EN
                        if (cmd_q == CMD_HARD) begin
                            // Each clean step commits and probes one row lower.
                            if (chk_err) begin
                                {cand_x_q, cand_y_q, cand_rot_q} <= {pos_x_q, pos_y_q, pos_rot_q};
                                state_q <= S_LOCK;
                            end else begin
                                pos_y_q <= cand_y_q;
                                cnt_q   <= 3'd0;
                                if (cand_y_q == Y_MAX) state_q <= S_LOCK;
                                else cand_y_q <= cand_y_q + 5'd1;
                            end
                        end else
`endif
                        if (cmd_q == CMD_DOWN && chk_err) begin
                            // Blocked soft drop locks directly, keeping the
                            // probed command latency of 2+CHK_LAT.
                            {cand_x_q, cand_y_q, cand_rot_q} <= {pos_x_q, pos_y_q, pos_rot_q};
                            state_q <= S_LOCK;
                        end else begin
                            err_q   <= chk_err;
                            state_q <= S_RESOLVE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_RESOLVE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                    if (!rej_q && !err_q) begin
                        {pos_x_q, pos_y_q, pos_rot_q} <= {cand_x_q, cand_y_q, cand_rot_q};
                        accepted_q <= 1'b1;
                    end else if (!rej_q && cmd_q == CMD_SPAWN) begin
                        // Overlapping spawn stays displayed.
                        {pos_x_q, pos_y_q, pos_rot_q} <= {cand_x_q, cand_y_q, cand_rot_q};
                        game_over_q <= 1'b1;
                    end else begin
                        {cand_x_q, cand_y_q, cand_rot_q} <= {pos_x_q, pos_y_q, pos_rot_q};
                    end
                end
                S_LOCK: begin
                    lock_q  <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign cand_x     = cand_x_q;
    assign cand_y     = cand_y_q;
    assign cand_rot   = cand_rot_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign pos_rot    = pos_rot_q;
    assign done       = done_q;
    assign accepted   = accepted_q;
    assign lock_pulse = lock_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_tetris_move_ctrl.sv
module tb_tetris_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [4:0] cand_x, cand_y, pos_x, pos_y;
  logic [1:0] cand_rot, pos_rot;
  logic       chk_err;
  logic       done, accepted, lock_pulse, game_over;

  logic err_val;
  logic hd_mode;
  // Modelled checker: constant error per command, or a floor at row 12.
  assign chk_err = hd_mode ? (cand_y == 5'd12) : err_val;

  tetris_move_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot), .chk_err(chk_err),
    .pos_x(pos_x), .pos_y(pos_y), .pos_rot(pos_rot), .done(done), .accepted(accepted),
    .lock_pulse(lock_pulse), .game_over(game_over)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct packed {
    logic       acc;
    logic [4:0] px;
    logic [4:0] py;
    logic [1:0] prot;
    logic       go;
    int         lat;
    int         locks;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   neg_cnt = 0;
  int   acc_neg = 0;
  int   lock_seen = 0;
  int   done_cnt = 0;
  int   pushed = 0;
  logic cand_oob = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (!rst_n) begin
      lock_seen = 0;
    end else begin
      if (cand_x >= 5'd20) cand_oob = 1'b1;
      if (lock_pulse) lock_seen++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("accepted", int'(accepted), int'(e.acc));
          chk("pos_x", int'(pos_x), int'(e.px));
          chk("pos_y", int'(pos_y), int'(e.py));
          chk("pos_rot", int'(pos_rot), int'(e.prot));
          chk("game_over", int'(game_over), int'(e.go));
          chk("latency", neg_cnt - acc_neg - 1, e.lat);
          chk("lock_count", lock_seen, e.locks);
          if (lock_pulse) begin
            chk("lock_cand_x", int'(cand_x), int'(e.px));
            chk("lock_cand_y", int'(cand_y), int'(e.py));
          end
          lock_seen = 0;
        end
      end
    end
  end

  // driver task
  task automatic run(input logic [2:0] c, input logic err, input logic acc,
                     input int px, input int py, input int prot, input logic go,
                     input int lat, input int locks);
    exp_t e;
    e.acc = acc; e.px = 5'(px); e.py = 5'(py); e.prot = 2'(prot);
    e.go = go; e.lat = lat; e.locks = locks;
    exp_q.push_back(e);
    pushed++;
    @(negedge clk); #1;
    err_val = err; cmd = c; cmd_valid = 1'b1;
    @(posedge clk);
    acc_neg = neg_cnt;
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pos_x"}, int'(pos_x), 8);
    chk({tag, "_pos_y"}, int'(pos_y), 0);
    chk({tag, "_pos_rot"}, int'(pos_rot), 0);
    chk({tag, "_cand_x"}, int'(cand_x), 8);
    chk({tag, "_cand_y"}, int'(cand_y), 0);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; err_val = 1'b0; hd_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    // left from spawn column
    run(3'd0, 1'b0, 1'b1, 7, 0, 0, 1'b0, 3, 0);
    // walk right to the wall
    for (int i = 0; i < 12; i++) run(3'd1, 1'b0, 1'b1, 8 + i, 0, 0, 1'b0, 3, 0);
    // right at the wall: pre-rejected, even with a clean checker
    run(3'd1, 1'b0, 1'b0, 19, 0, 0, 1'b0, 2, 0);
    // rotate 0->1->2->3->0, then a blocked rotate
    for (int i = 1; i <= 4; i++) run(3'd3, 1'b0, 1'b1, 19, 0, i % 4, 1'b0, 3, 0);
    run(3'd3, 1'b1, 1'b0, 19, 0, 0, 1'b0, 3, 0);
    // down to row 5, then a blocked down locks at row 5
    for (int i = 1; i <= 5; i++) run(3'd2, 1'b0, 1'b1, 19, i, 0, 1'b0, 3, 0);
    run(3'd2, 1'b1, 1'b0, 19, 5, 0, 1'b0, 3, 1);
    // down to the floor, then down at row 19 locks without a probe
    for (int i = 6; i <= 19; i++) run(3'd2, 1'b0, 1'b1, 19, i, 0, 1'b0, 3, 0);
    run(3'd2, 1'b0, 1'b0, 19, 19, 0, 1'b0, 2, 1);
    // clean spawn
    run(3'd4, 1'b0, 1'b1, 8, 0, 0, 1'b0, 3, 0);
    // hard drop
`ifdef TETRIS_HARD_DROP_EN
    hd_mode = 1'b1;
    run(3'd5, 1'b0, 1'b0, 8, 11, 0, 1'b0, 14, 1);
    hd_mode = 1'b0;
`else
    run(3'd5, 1'b0, 1'b0, 8, 0, 0, 1'b0, 2, 0);
`endif
    // illegal command
    run(3'd6, 1'b0, 1'b0, 8, 11 * int'(pos_y != 5'd0), 0, 1'b0, 2, 0);
    // blocked spawn ends the game, overlap stays displayed at spawn
    run(3'd4, 1'b1, 1'b0, 8, 0, 0, 1'b1, 3, 0);
    // any command after game over is rejected
    run(3'd0, 1'b0, 1'b0, 8, 0, 0, 1'b1, 2, 0);

    // reset in the middle of a command: no done pulse may follow
    @(negedge clk); #1;
    cmd = 3'd2; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midreset");
    repeat (5) @(negedge clk);

    // recovers normally
    run(3'd0, 1'b0, 1'b1, 7, 0, 0, 1'b0, 3, 0);

    chk("done_count", done_cnt, pushed);
    chk("cand_x_in_field", int'(cand_oob), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
